// File: rtl/captura_jogada.sv
// captura_jogada: player-input responder for the Jogo da Velha controller.
// While jogar is high it debounces the 9 cell buttons. Ambiguous presses are
// rejected, and so are presses on occupied cells. An accepted cell index is
// returned together with a one-cycle tem_jogada pulse.
// Optional build macro TIMEOUT_EN adds an idle-timeout pulse output.
module captura_jogada #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned TIMEOUT  = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic [8:0] botoes,
  input  logic [8:0] ocupadas,
  output logic       tem_jogada,
  output logic [3:0] jogada,
  output logic       jogada_invalida,
  output logic       timeout,
  output logic [2:0] db_estado
);

  typedef enum logic [2:0] {
    OCIOSO        = 3'd0,
    ESPERA_SOLTA  = 3'd1,
    ESPERA_APERTO = 3'd2,
    FILTRO        = 3'd3,
    VALIDA        = 3'd4,
    EMITE         = 3'd5,
    INVALIDA      = 3'd6
  } estado_t;

  // Reject parameter sets the debounce counter or timeout cannot represent
  if (DEBOUNCE < 1 || longint'(DEBOUNCE) >= (longint'(1) << CNT_W)) begin : g_erro_debounce
    $error("captura_jogada: DEBOUNCE must be >= 1 and fit in CNT_W bits");
  end
  if (TIMEOUT < 2) begin : g_erro_timeout
    $error("captura_jogada: TIMEOUT must be >= 2");
  end

  estado_t          estado_q, estado_d;
  logic [8:0]       padrao_q, padrao_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       jogada_q, jogada_d;
  logic [3:0]       indice;

  // Encode the captured one-hot pattern as a cell index 0..8
  always_comb begin
    indice = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      if (padrao_q[i]) indice = 4'(i);
    end
  end

  // Next-state logic: press capture, debounce filter and validation
  always_comb begin
    estado_d = estado_q;
    padrao_d = padrao_q;
    cnt_d    = cnt_q;
    jogada_d = jogada_q;
    case (estado_q)
      OCIOSO: begin
        if (jogar) estado_d = ESPERA_SOLTA;
      end
      ESPERA_SOLTA: begin
        if (botoes == '0) estado_d = ESPERA_APERTO;
      end
      ESPERA_APERTO: begin
        if ($onehot(botoes)) begin
          padrao_d = botoes;
          cnt_d    = CNT_W'(1);
          estado_d = FILTRO;
        end else if (botoes != '0) begin
          estado_d = ESPERA_SOLTA;
        end
      end
      FILTRO: begin
        if (botoes != padrao_q) begin
          cnt_d    = '0;
          estado_d = ESPERA_APERTO;
        end else if (cnt_q == CNT_W'(DEBOUNCE)) begin
          estado_d = VALIDA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      VALIDA: begin
        if ((padrao_q & ocupadas) != '0) begin
          estado_d = INVALIDA;
        end else begin
          jogada_d = indice;
          estado_d = EMITE;
        end
      end
      EMITE, INVALIDA: begin
        estado_d = jogar ? ESPERA_SOLTA : OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
    // Dropping the request aborts everything except the single-cycle result
    // states; the held move must not be overwritten by an aborted VALIDA.
    if (!jogar && estado_q != EMITE && estado_q != INVALIDA) begin
      estado_d = OCIOSO;
      padrao_d = padrao_q;
      cnt_d    = '0;
      jogada_d = jogada_q;
    end
  end

  // State, pattern, debounce counter and move registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= OCIOSO;
      padrao_q <= '0;
      cnt_q    <= '0;
      jogada_q <= '0;
    end else begin
      estado_q <= estado_d;
      padrao_q <= padrao_d;
      cnt_q    <= cnt_d;
      jogada_q <= jogada_d;
    end
  end

  assign tem_jogada      = (estado_q == EMITE);
  assign jogada_invalida = (estado_q == INVALIDA);
  assign jogada          = jogada_q;
  assign db_estado       = estado_q;

`ifdef TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_limpa, to_conta, to_fim;

  // Idle counter: runs while a move is awaited, wraps with a pulse at TIMEOUT-1
  always_comb begin
    to_limpa = (estado_q == OCIOSO) || (estado_q == EMITE) || (estado_q == INVALIDA);
    to_conta = jogar && !to_limpa;
    to_fim   = to_conta && (to_cnt_q == TO_W'(TIMEOUT - 1));
    to_cnt_d = to_cnt_q;
    if (to_limpa || to_fim) begin
      to_cnt_d = '0;
    end else if (to_conta) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  // Idle counter register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end

  assign timeout = to_fim;
`else
  assign timeout = 1'b0;
`endif

endmodule
